// File: rtl/avr_irq_pkg.sv
// avr_irq_pkg -- shared definitions for the avr_irq_ctrl interrupt controller.
//   irq_reg_e  : register offsets inside the 4-register I/O window
//   IRQ_MAX_CH : largest supported channel count
package avr_irq_pkg;

  typedef enum logic [1:0] {
    IRQ_PEND = 2'd0,  // pending bits, write-1-to-clear (edge channels)
    IRQ_MASK = 2'd1,  // channel enable
    IRQ_EDGE = 2'd2,  // 1 = rising-edge sensing, 0 = level sensing
    IRQ_CTRL = 2'd3   // read: {iflag, 0000, ivect[2:0]}; write: software trigger
  } irq_reg_e;

  localparam int IRQ_MAX_CH = 8;

endpackage

// File: rtl/irq_prio_sel.sv
// irq_prio_sel -- combinational rotating priority selector.
// Searches the eligible vector starting at start_i and wrapping from N-1 to 0;
// the first set bit wins.
// Ports:
//   elig_i  [N-1:0]  eligible channels
//   start_i [W-1:0]  highest-priority channel (0 gives plain lowest-index-first)
//   found_o          at least one channel eligible
//   idx_o   [W-1:0]  winning channel index (0 when none found)
module irq_prio_sel #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] elig_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    logic         hit;
    logic [W-1:0] sel;
    int           base;
    int           ch;
    hit  = 1'b0;
    sel  = '0;
    // An out-of-range start pointer cannot occur in normal use; fall back to 0.
    base = (int'(start_i) < N) ? int'(start_i) : 0;
    ch   = 0;
    for (int off = 0; off < N; off++) begin
      ch = base + off;
      if (ch >= N) begin
        ch = ch - N;
      end
      if (!hit && elig_i[ch]) begin
        hit = 1'b1;
        sel = W'(ch);
      end
    end
    found_o = hit;
    idx_o   = sel;
  end

endmodule

// File: rtl/avr_irq_ctrl.sv
// avr_irq_ctrl -- interrupt controller between peripherals and the AVR core.
// Per-channel pending latches (edge or level sensed), mask, software trigger,
// acknowledge-driven clearing, registered iflag/ivect towards the core.
// Build option: define AVR_IRQ_RR_EN for round-robin arbitration; without it
// the lowest eligible index always wins.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   irq      [NUM_IRQ]   peripheral request lines (synchronous to clk)
//   io_re, io_we         pre-decoded I/O read / write strobes
//   io_a     [2]         register offset (see avr_irq_pkg::irq_reg_e)
//   io_din   [8]         write data
//   io_dout  [8]         read data, 0 when io_re is low
//   iflag, ivect         registered interrupt request and vector to the core
//   ack, ack_vect        one-cycle acknowledge from the core and its vector
module avr_irq_ctrl
  import avr_irq_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int VECT_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               io_re,
  input  logic               io_we,
  input  logic [1:0]         io_a,
  input  logic [7:0]         io_din,
  output logic [7:0]         io_dout,
  output logic               iflag,
  output logic [VECT_W-1:0]  ivect,
  input  logic               ack,
  input  logic [VECT_W-1:0]  ack_vect
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic               iflag_q;
  logic [VECT_W-1:0]  ivect_q;

  logic               wr_pend, wr_mask, wr_edge, wr_ctrl;
  logic [NUM_IRQ-1:0] eligible;
  logic [VECT_W-1:0]  start_ptr;
  logic               sel_found;
  logic [VECT_W-1:0]  sel_idx;

  // Channel counts below 8 leave the upper write-data bits unused.
  logic               unused_din;
  assign unused_din = &{1'b0, io_din};

  assign wr_pend = io_we && (io_a == IRQ_PEND);
  assign wr_mask = io_we && (io_a == IRQ_MASK);
  assign wr_edge = io_we && (io_a == IRQ_EDGE);
  assign wr_ctrl = io_we && (io_a == IRQ_CTRL);

  assign mask_d = wr_mask ? io_din[NUM_IRQ-1:0] : mask_q;
  assign edge_d = wr_edge ? io_din[NUM_IRQ-1:0] : edge_q;

  // Pending latch per channel. The mode in force during this cycle decides
  // the next value, so switching a channel from level to edge carries the
  // level-sampled value over unchanged.
  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_chan
      logic rise, sw_set, w1c, ack_hit;
      assign rise    = irq[gi] & ~irq_q[gi];
      assign sw_set  = wr_ctrl & io_din[gi];
      assign w1c     = wr_pend & io_din[gi];
      assign ack_hit = ack && (ack_vect == VECT_W'(gi));
      // Set terms are ORed after the clear so that set wins.
      assign pend_d[gi] = edge_q[gi]
                        ? (rise | sw_set | (pend_q[gi] & ~(w1c | ack_hit)))
                        : irq[gi];
    end
  endgenerate

  assign eligible = pend_q & mask_q;

`ifdef AVR_IRQ_RR_EN
  logic [VECT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic              ack_ok;

  // Out-of-range acknowledges leave the pointer alone.
  assign ack_ok   = ack && (int'(ack_vect) < NUM_IRQ);
  assign rr_ptr_d = !ack_ok                         ? rr_ptr_q :
                    (int'(ack_vect) == NUM_IRQ - 1) ? '0       :
                                                      ack_vect + VECT_W'(1);
  assign start_ptr = rr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign start_ptr = '0;
`endif

  irq_prio_sel #(
    .N (NUM_IRQ),
    .W (VECT_W)
  ) u_sel (
    .elig_i  (eligible),
    .start_i (start_ptr),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      iflag_q <= 1'b0;
      ivect_q <= '0;
    end else begin
      irq_q   <= irq;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      iflag_q <= sel_found;
      ivect_q <= sel_found ? sel_idx : '0;
    end
  end

  assign iflag = iflag_q;
  assign ivect = ivect_q;

  always_comb begin
    io_dout = 8'h00;
    if (io_re) begin
      case (io_a)
        IRQ_PEND: io_dout = 8'(pend_q);
        IRQ_MASK: io_dout = 8'(mask_q);
        IRQ_EDGE: io_dout = 8'(edge_q);
        default:  io_dout = {iflag_q, 4'b0000, 3'(ivect_q)};
      endcase
    end
  end

endmodule

// File: tb/tb_avr_irq_ctrl.sv
// tb_avr_irq_ctrl -- self-checking bench for avr_irq_ctrl.
// Default build: table of one-cycle vectors for fixed priority.
// With AVR_IRQ_RR_EN: round-robin sequence on a 3-channel instance.
module tb_avr_irq_ctrl;
  import avr_irq_pkg::*;

`ifdef AVR_IRQ_RR_EN
  localparam int N_CH = 3;
`else
  localparam int N_CH = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] irq_r = '0;
  logic       io_re = 1'b0;
  logic       io_we = 1'b0;
  logic [1:0] io_a = '0;
  logic [7:0] io_din = '0;
  logic [7:0] io_dout;
  logic       iflag;
  logic [1:0] ivect;
  logic       ack = 1'b0;
  logic [1:0] ack_vect = '0;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  avr_irq_ctrl #(
    .NUM_IRQ (N_CH),
    .VECT_W  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq      (irq_r[N_CH-1:0]),
    .io_re    (io_re),
    .io_we    (io_we),
    .io_a     (io_a),
    .io_din   (io_din),
    .io_dout  (io_dout),
    .iflag    (iflag),
    .ivect    (ivect),
    .ack      (ack),
    .ack_vect (ack_vect)
  );

  typedef struct {
    logic [3:0] irq;
    logic       we;
    logic [1:0] a;
    logic [7:0] din;
    logic       ack;
    logic [1:0] av;
    logic [7:0] pend;
    logic       fl;
    logic [1:0] iv;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic [3:0] irq, logic we, logic [1:0] a, logic [7:0] din,
                              logic ak, logic [1:0] av, logic [7:0] pend, logic fl,
                              logic [1:0] iv);
    vec_t v;
    v.irq = irq; v.we = we; v.a = a; v.din = din; v.ack = ak; v.av = av;
    v.pend = pend; v.fl = fl; v.iv = iv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end else begin
      $display("ok   %s: %02h", nm, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    io_we = 1'b0;
    ack   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    io_re = 1'b1;
    io_a  = a;
    #1;
    d = io_dout;
    io_re = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    io_we  = 1'b1;
    io_a   = a;
    io_din = d;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #2;
    chk("rst iflag", {7'b0, iflag}, 8'h00);
    chk("rst ivect", {6'b0, ivect}, 8'h00);
    chk("rst dout idle", io_dout, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(IRQ_PEND, d); chk("rst pend", d, 8'h00);
    rd(IRQ_MASK, d); chk("rst mask", d, 8'h00);
    rd(IRQ_EDGE, d); chk("rst edge", d, 8'h00);
    rd(IRQ_CTRL, d); chk("rst ctrl", d, 8'h00);

`ifndef AVR_IRQ_RR_EN
    // ---------------- fixed-priority vector table ----------------
    // irq, we, addr, din, ack, ack_vect | pend, iflag, ivect after the edge
    vq.push_back(mk(4'h0, 1, IRQ_MASK, 8'h0F, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(4'h0, 1, IRQ_EDGE, 8'h00, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(4'h4, 0, 0, 8'h00, 0, 0, 8'h04, 0, 0));          // level irq2
    vq.push_back(mk(4'h4, 0, 0, 8'h00, 0, 0, 8'h04, 1, 2));
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 2));          // drop
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(4'h0, 1, IRQ_EDGE, 8'h0F, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(4'h8, 0, 0, 8'h00, 0, 0, 8'h08, 0, 0));          // pulse irq3
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 0, 0, 8'h08, 1, 3));
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 1, 3, 8'h00, 1, 3));          // ack 3
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(4'h6, 0, 0, 8'h00, 0, 0, 8'h06, 0, 0));          // ch1+ch2
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 0, 0, 8'h06, 1, 1));
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 1, 1, 8'h04, 1, 1));          // ack 1
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 0, 0, 8'h04, 1, 2));
    vq.push_back(mk(4'h0, 1, IRQ_CTRL, 8'h02, 0, 0, 8'h06, 1, 2));   // sw trig 1
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 0, 0, 8'h06, 1, 1));
    vq.push_back(mk(4'h0, 1, IRQ_MASK, 8'h04, 0, 0, 8'h06, 1, 1));   // mask keeps pend
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 0, 0, 8'h06, 1, 2));
    vq.push_back(mk(4'h0, 1, IRQ_PEND, 8'h06, 0, 0, 8'h00, 1, 2));   // W1C
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(4'h0, 1, IRQ_MASK, 8'h0F, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(4'h0, 1, IRQ_EDGE, 8'h01, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(4'h0, 1, IRQ_CTRL, 8'h01, 0, 0, 8'h01, 0, 0));   // sw trig 0
    vq.push_back(mk(4'h1, 1, IRQ_PEND, 8'h01, 0, 0, 8'h01, 1, 0));   // W1C + rise
    vq.push_back(mk(4'h1, 1, IRQ_PEND, 8'h01, 0, 0, 8'h00, 1, 0));   // W1C alone
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(4'h2, 1, IRQ_CTRL, 8'h04, 0, 0, 8'h02, 0, 0));   // level: no sw trig
    vq.push_back(mk(4'h2, 1, IRQ_PEND, 8'h02, 0, 0, 8'h02, 1, 1));   // level: no W1C
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 1, 1, 8'h00, 1, 1));
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(4'h4, 0, 0, 8'h00, 0, 0, 8'h04, 0, 0));
    vq.push_back(mk(4'h4, 1, IRQ_EDGE, 8'h05, 0, 0, 8'h04, 1, 2));   // level->edge
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 0, 0, 8'h04, 1, 2));          // pend kept
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 1, 2, 8'h00, 1, 2));
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(4'h1, 0, 0, 8'h00, 1, 0, 8'h01, 0, 0));          // set beats ack
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 0, 0, 8'h01, 1, 0));
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 0));
    vq.push_back(mk(4'h0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));

    foreach (vq[i]) begin
      irq_r    = vq[i].irq;
      io_we    = vq[i].we;
      io_a     = vq[i].a;
      io_din   = vq[i].din;
      ack      = vq[i].ack;
      ack_vect = vq[i].av;
      step();
      rd(IRQ_PEND, d);
      chk($sformatf("vec%0d pend", i), d, vq[i].pend);
      chk($sformatf("vec%0d iflag", i), {7'b0, iflag}, {7'b0, vq[i].fl});
      chk($sformatf("vec%0d ivect", i), {6'b0, ivect}, {6'b0, vq[i].iv});
    end
    rd(IRQ_MASK, d); chk("tbl mask", d, 8'h0F);
    rd(IRQ_EDGE, d); chk("tbl edge", d, 8'h05);
`else
    // ---------------- round-robin sequence (3 channels) ----------------
    wr(IRQ_MASK, 8'h07);
    wr(IRQ_EDGE, 8'h07);
    wr(IRQ_CTRL, 8'h07);
    step();
    chk("rr first ivect", {6'b0, ivect}, 8'h00);
    chk("rr first iflag", {7'b0, iflag}, 8'h01);
    for (int k = 0; k < 3; k++) begin
      // Acknowledge the current winner and re-trigger it in the same cycle.
      ack      = 1'b1;
      ack_vect = 2'(k);
      io_we    = 1'b1;
      io_a     = IRQ_CTRL;
      io_din   = 8'(1 << k);
      step();
      step();
      chk($sformatf("rr ack%0d ivect", k), {6'b0, ivect}, 8'((k + 1) % 3));
      rd(IRQ_PEND, d);
      chk($sformatf("rr ack%0d pend", k), d, 8'h07);
    end
    ack      = 1'b1;
    ack_vect = 2'd3;
    step();
    step();
    chk("rr oor ivect", {6'b0, ivect}, 8'h00);
    rd(IRQ_PEND, d);
    chk("rr oor pend", d, 8'h07);
`endif

    // ---------------- asynchronous reset mid-operation ----------------
    irq_r = 4'h0;
    wr(IRQ_MASK, 8'h0F);
    wr(IRQ_EDGE, 8'h00);
    irq_r = 4'h4;
    repeat (3) step();
    chk("pre-rst iflag", {7'b0, iflag}, 8'h01);
    chk("pre-rst ivect", {6'b0, ivect}, 8'h02);
    rd(IRQ_CTRL, d); chk("pre-rst ctrl", d, 8'h82);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst iflag", {7'b0, iflag}, 8'h00);
    rd(IRQ_PEND, d); chk("async rst pend", d, 8'h00);
    rd(IRQ_MASK, d); chk("async rst mask", d, 8'h00);
    rd(IRQ_EDGE, d); chk("async rst edge", d, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    irq_r = 4'h0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
